// File: rtl/usb_dbg_pkg.sv
// usb_dbg_pkg: scheduler state encoding and debug-console constants
package usb_dbg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOG, S_RESTART, S_FLUSH, S_REQ, S_RELEASE} state_e;
  localparam logic [1:0] RELEASE_LAST = 2'd2;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
endpackage

// File: rtl/usb_tx_holding_reg.sv
// usb_tx_holding_reg: single-entry tx byte register, valid held until the UART takes it
module usb_tx_holding_reg (
  input  logic       clk48,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o
);
  logic [7:0] data_q;
  logic       valid_q;
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) data_q <= data_i;
      valid_q <= load_i | (valid_q & ~ready_i);
    end
  end
  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/usb_status_scheduler.sv
// usb_status_scheduler: pulls annunciator frames onto the UART and interleaves debug log bytes
module usb_status_scheduler
  import usb_dbg_pkg::*;
#(
  parameter int REFRESH_CYCLES = 4800000,
  parameter int FRAME_BYTES    = 320,
  parameter int DV_TIMEOUT     = 16
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic        enable,
  input  logic        force_refresh,
  output logic        ann_rst,
  output logic        ann_inc,
  input  logic [7:0]  ann_q,
  input  logic        ann_dv,
  input  logic        log_valid,
  input  logic [7:0]  log_data,
  output logic        log_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        timeout_err
);
  localparam int TW  = $clog2(REFRESH_CYCLES + 1);
  localparam int TOW = $clog2(DV_TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMER_MAX  = TW'(REFRESH_CYCLES - 1);
  localparam logic [9:0]     BYTES_LAST = 10'(FRAME_BYTES - 1);
  localparam logic [TOW-1:0] TO_LAST    = TOW'(DV_TIMEOUT - 1);
  state_e         state_q;
  logic [TW-1:0]  timer_q;
  logic [TOW-1:0] to_q;
  logic [9:0]     bytes_q;
  logic [1:0]     rel_q;
  logic [15:0]    frame_count_q;
  logic           force_q, ann_rst_q, ann_inc_q, log_ready_q, busy_q, timeout_err_q;
  logic           due, start, load;
  logic [7:0]     load_data;
  assign due       = timer_q == TIMER_MAX || force_q || force_refresh;
  assign start     = state_q == S_IDLE && due && enable;
  assign load      = (state_q == S_REQ && ann_dv) || (state_q == S_LOG && log_ready_q && log_valid);
  assign load_data = state_q == S_LOG ? log_data : ann_q;
  // force_q comes out of reset set so the annunciator is restarted straight after any reset
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      force_q       <= 1'b1;
      to_q          <= '0;
      bytes_q       <= '0;
      rel_q         <= '0;
      frame_count_q <= '0;
      ann_rst_q     <= 1'b0;
      ann_inc_q     <= 1'b0;
      log_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timer_q     <= start ? '0 : timer_q == TIMER_MAX ? timer_q : timer_q + 1'b1;
      force_q     <= !start && (force_q || force_refresh);
      ann_rst_q   <= 1'b0;
      log_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RESTART;
            ann_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            bytes_q   <= '0;
          end else if (log_valid) begin
            state_q     <= S_LOG;
            log_ready_q <= 1'b1;
          end
        end
        S_LOG: if (log_ready_q ? !log_valid : tx_ready) state_q <= S_IDLE;
        S_RESTART: state_q <= S_FLUSH;
        // dv seen here is the annunciator's stale post-reset byte
        S_FLUSH: begin
          state_q   <= S_REQ;
          ann_inc_q <= 1'b1;
          to_q      <= '0;
        end
        S_REQ: begin
          if (ann_dv) begin
            state_q   <= S_RELEASE;
            ann_inc_q <= 1'b0;
            rel_q     <= '0;
          end else if (to_q == TO_LAST) begin
            state_q       <= S_IDLE;
            ann_inc_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        // three low cycles clear the annunciator inhibit and cap throughput at one byte per four cycles
        S_RELEASE: begin
          if (rel_q != RELEASE_LAST) begin
            rel_q <= rel_q + 1'b1;
          end else if (!tx_valid || tx_ready) begin
            bytes_q <= bytes_q + 1'b1;
            if (bytes_q == BYTES_LAST) begin
              state_q       <= S_IDLE;
              busy_q        <= 1'b0;
              frame_count_q <= frame_count_q + 1'b1;
            end else begin
              state_q   <= S_REQ;
              ann_inc_q <= 1'b1;
              to_q      <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  usb_tx_holding_reg u_hold (
    .clk48   (clk48),
    .rst     (rst),
    .load_i  (load),
    .data_i  (load_data),
    .ready_i (tx_ready),
    .data_o  (tx_data),
    .valid_o (tx_valid)
  );
  assign ann_rst     = ann_rst_q;
  assign ann_inc     = ann_inc_q;
  assign log_ready   = log_ready_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_usb_status_scheduler.sv
// tb_usb_status_scheduler: directed frame, stall, log, timeout, force and reset checks
module tb_usb_status_scheduler;
  logic        clk48 = 1'b0, rst = 1'b1, enable = 1'b0, force_refresh = 1'b0;
  logic        ann_dv = 1'b0, log_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0]  ann_q = 8'h00, log_data = 8'h00;
  logic        ann_rst, ann_inc, log_ready, tx_valid, busy, timeout_err;
  logic [7:0]  tx_data;
  logic [15:0] frame_count;
  int          pass_cnt = 0, total = 0, cyc, ready_viol = 0;
  logic [7:0]  rom [4];
  logic        spur_en = 1'b1, never_dv = 1'b0, wait_low = 1'b0;
  logic [1:0]  ptr = 2'd0;
  logic [7:0]  txq [$];
  int          rstq [$];

  typedef struct packed {
    logic [3:0][7:0] bytes;
    logic [15:0]     fc;
    int              rst_cyc;
  } vec_t;

  usb_status_scheduler #(.REFRESH_CYCLES(100), .FRAME_BYTES(4), .DV_TIMEOUT(16)) dut (
    .clk48(clk48), .rst(rst), .enable(enable), .force_refresh(force_refresh),
    .ann_rst(ann_rst), .ann_inc(ann_inc), .ann_q(ann_q), .ann_dv(ann_dv),
    .log_valid(log_valid), .log_data(log_data), .log_ready(log_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err)
  );

  always #5 clk48 = ~clk48;

  always @(posedge clk48 or posedge rst) cyc <= rst ? 0 : cyc + 1;

  // annunciator: stale 0x55 dv after restart, one byte per inc, needs inc low before the next
  always @(posedge clk48) begin
    ann_dv <= 1'b0;
    if (ann_rst) begin
      ptr      <= 2'd0;
      wait_low <= 1'b0;
      ann_dv   <= spur_en;
      ann_q    <= 8'h55;
    end else if (ann_inc && !wait_low && !never_dv) begin
      ann_dv   <= 1'b1;
      ann_q    <= rom[ptr];
      ptr      <= ptr + 2'd1;
      wait_low <= 1'b1;
    end else if (!ann_inc) begin
      wait_low <= 1'b0;
    end
  end

  always @(negedge clk48) if (!rst) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (ann_rst) rstq.push_back(cyc);
    if (busy && log_ready) ready_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return ann_rst;
      1: return ann_inc;
      2: return tx_valid;
      3: return busy;
      default: return log_ready;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk48);
      ok = sig(w);
    end
  endtask

  task automatic wait_fc(input logic [15:0] n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk48);
      ok = frame_count == n;
    end
  endtask

  task automatic check_txq(input string name, input logic [3:0][7:0] exp);
    check({name, " count"}, txq.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s byte%0d", name, k), k < txq.size() ? txq[k] : 8'hxx, exp[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    logic [7:0] d;
    int n, t0, t1;
    vec_t vecs [3];
    vecs[0] = '{bytes: {8'h7E, 8'h0C, 8'h48, 8'h1B}, fc: 16'd1, rst_cyc: 1};
    vecs[1] = '{bytes: {8'h00, 8'hFF, 8'h5A, 8'hA0}, fc: 16'd2, rst_cyc: 101};
    vecs[2] = '{bytes: {8'hC3, 8'h33, 8'h0A, 8'h0D}, fc: 16'd3, rst_cyc: 201};

    repeat (3) @(negedge clk48);
    check("reset outputs", {ann_rst, ann_inc, log_ready, tx_valid, busy, timeout_err, frame_count, tx_data}, 0);
    for (int k = 0; k < 4; k++) rom[k] = vecs[0].bytes[k];
    enable = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk48); #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) rom[k] = vecs[i].bytes[k];
      wait_fc(vecs[i].fc, ok);
      check($sformatf("frame%0d done", i), ok, 1);
      check_txq($sformatf("frame%0d", i), vecs[i].bytes);
      check($sformatf("frame%0d ann_rst cycle", i), rstq.size() > i ? rstq[i] : -1, vecs[i].rst_cyc);
      txq.delete();
    end

    rom = '{8'h61, 8'h62, 8'h63, 8'h64};
    tx_ready = 1'b0;
    wait_sig(2, 200, ok);
    check("stall byte1 valid", ok, 1);
    @(posedge clk48); #1 tx_ready = 1'b1;
    @(posedge clk48); #1 tx_ready = 1'b0;
    wait_sig(2, 50, ok);
    check("stall byte2 valid", ok, 1);
    d = tx_data;
    n = 0;
    repeat (50) begin
      @(negedge clk48);
      if (!tx_valid || tx_data !== d || ann_inc) n++;
    end
    check("stall hold violations", n, 0);
    check("stall byte2 value", d, 8'h62);
    @(posedge clk48); #1 tx_ready = 1'b1;
    wait_fc(16'd4, ok);
    check("stall frame done", ok, 1);
    check_txq("stall", {8'h64, 8'h63, 8'h62, 8'h61});
    txq.delete();

    rom = '{8'h71, 8'h72, 8'h73, 8'h74};
    wait_sig(3, 200, ok);
    check("log frame busy", ok, 1);
    @(posedge clk48); #1 log_valid = 1'b1; log_data = 8'h41;
    wait_sig(4, 100, ok);
    check("log1 ready", ok, 1);
    check("log1 waits for frame", busy, 0);
    @(posedge clk48); #1 log_data = 8'h42;
    wait_sig(4, 20, ok);
    check("log2 ready", ok, 1);
    @(posedge clk48); #1 log_valid = 1'b0;
    repeat (3) @(negedge clk48);
    check("log tx count", txq.size(), 6);
    check("log byte 0x41", txq.size() > 4 ? txq[4] : 8'hxx, 8'h41);
    check("log byte 0x42", txq.size() > 5 ? txq[5] : 8'hxx, 8'h42);
    check("log frame byte0", txq.size() > 0 ? txq[0] : 8'hxx, 8'h71);
    check("log_ready while busy", ready_viol, 0);
    check("logs before next ann_rst", rstq.size(), 5);
    txq.delete();

    never_dv = 1'b1;
    wait_sig(1, 200, ok);
    check("timeout inc raised", ok, 1);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk48);
      if (!ann_inc) break;
      n++;
    end
    check("timeout inc cycles", n, 16);
    check("timeout_err set", timeout_err, 1);
    check("timeout busy low", busy, 0);
    check("timeout frame_count", frame_count, 5);

    never_dv = 1'b0;
    repeat (3) @(posedge clk48);
    #1 force_refresh = 1'b1;
    t0 = cyc;
    @(posedge clk48); #1 force_refresh = 1'b0;
    wait_sig(0, 10, ok);
    t1 = cyc;
    check("force ann_rst seen", ok, 1);
    check("force ann_rst latency", (t1 == t0 + 1 || t1 == t0 + 2), 1);
    wait_fc(16'd6, ok);
    check("force frame done", ok, 1);
    wait_sig(0, 200, ok);
    check("timer restarted", ok ? cyc - t1 : -1, 100);

    never_dv = 1'b1;
    wait_sig(1, 20, ok);
    check("reset-in-REQ inc high", ok, 1);
    #2 rst = 1'b1;
    #1 check("async reset outputs", {ann_inc, busy, tx_valid, timeout_err, frame_count}, 0);
    never_dv = 1'b0;
    rstq.delete();
    @(posedge clk48); #1 rst = 1'b0;
    wait_sig(0, 5, ok);
    check("ann_rst after reset", ok ? cyc : -1, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
